// File: rtl/dtc_stream_sched.sv
// Round-robin scheduler that time-shares one external decision-tree classifier among NREQ requesters.
// Optional per-class result histogram is built only when DTC_CLASS_HIST_EN is defined.
module dtc_stream_sched #(
  parameter int NREQ   = 4,
  parameter int FEAT_W = 7,
  parameter int CLS_W  = 2,
  parameter int CNT_W  = 16,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*FEAT_W-1:0]   req_feat,
  output logic [NREQ-1:0]          req_ready,
  output logic [FEAT_W-1:0]        tree_inp,
  input  logic [CLS_W-1:0]         tree_outp,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [CLS_W-1:0]         res_class,
  output logic [ID_W-1:0]          res_id,
  output logic                     busy
`ifdef DTC_CLASS_HIST_EN
  ,
  input  logic                     hist_clr,
  output logic [(1<<CLS_W)*CNT_W-1:0] hist
`endif
);

  typedef enum logic [1:0] {IDLE, EVAL, OUT} state_t;

  state_t              state_reg, state_next;
  logic [ID_W-1:0]     rr_ptr_reg;
  logic [FEAT_W-1:0]   feat_reg;
  logic [CLS_W-1:0]    cls_reg;
  logic [ID_W-1:0]     id_reg;

  logic [ID_W-1:0]     rot_idx [NREQ];
  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [FEAT_W-1:0]   grant_feat;
  logic                accept;
  logic                done;

  if (NREQ < 2 || CNT_W < 1) begin : g_param_check
    $error("dtc_stream_sched: NREQ must be >= 2 and CNT_W >= 1");
  end

  // rot_idx[k] is the requester visited k-th in the scan that starts at rr_ptr
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
    logic [ID_W:0] sum;
    assign sum = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
    assign rot_idx[gi] = (sum >= (ID_W+1)'(NREQ)) ? ID_W'(sum - (ID_W+1)'(NREQ)) : sum[ID_W-1:0];
  end

  // Scan from the back so the earliest position in round-robin order wins
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[rot_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = rot_idx[k];
      end
    end
  end

  always_comb begin
    grant_feat = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == ID_W'(k)) grant_feat = req_feat[k*FEAT_W +: FEAT_W];
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    done       = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (grant_found) begin
          accept     = 1'b1;
          state_next = EVAL;
        end
      end
      EVAL: state_next = OUT;
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Gated by rst_n so no grant is advertised while the registers are held in reset
  assign req_ready = (accept && rst_n) ? (NREQ'(1) << grant_idx) : '0;
  assign tree_inp  = feat_reg;
  assign res_class = cls_reg;
  assign res_id    = id_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_reg <= '0;
      feat_reg   <= '0;
      cls_reg    <= '0;
      id_reg     <= '0;
    end else begin
      if (accept) begin
        feat_reg   <= grant_feat;
        id_reg     <= grant_idx;
        rr_ptr_reg <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (state_reg == EVAL) cls_reg <= tree_outp;
    end
  end

`ifdef DTC_CLASS_HIST_EN
  for (genvar gi = 0; gi < (1 << CLS_W); gi++) begin : g_hist
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                                 cnt_reg <= '0;
      else if (hist_clr)                                          cnt_reg <= '0;
      else if (done && cls_reg == CLS_W'(gi) && cnt_reg != '1)    cnt_reg <= cnt_reg + 1'b1;
    end
    assign hist[gi*CNT_W +: CNT_W] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_dtc_stream_sched.sv
// Directed bench for dtc_stream_sched with a small 7-in/2-out decision tree as the shared core.
// Histogram scenario runs only when DTC_CLASS_HIST_EN is defined.
module tb_dtc_stream_sched;

  localparam int NREQ   = 4;
  localparam int FEAT_W = 7;
  localparam int CLS_W  = 2;
`ifdef DTC_CLASS_HIST_EN
  localparam int CNT_W  = 2;
`else
  localparam int CNT_W  = 16;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*FEAT_W-1:0] req_feat;
  logic [NREQ-1:0]        req_ready;
  logic [FEAT_W-1:0]      tree_inp;
  logic [CLS_W-1:0]       tree_outp;
  logic                   res_valid;
  logic                   res_ready;
  logic [CLS_W-1:0]       res_class;
  logic [1:0]             res_id;
  logic                   busy;
`ifdef DTC_CLASS_HIST_EN
  logic                   hist_clr;
  logic [(1<<CLS_W)*CNT_W-1:0] hist;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  dtc_stream_sched #(.NREQ(NREQ), .FEAT_W(FEAT_W), .CLS_W(CLS_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_feat(req_feat), .req_ready(req_ready),
    .tree_inp(tree_inp), .tree_outp(tree_outp), .res_valid(res_valid), .res_ready(res_ready),
    .res_class(res_class), .res_id(res_id), .busy(busy)
`ifdef DTC_CLASS_HIST_EN
    , .hist_clr(hist_clr), .hist(hist)
`endif
  );

  // Classifier core: bit2 or bit6 -> 11, else bit4 -> 10, else 01
  always_comb begin
    if (tree_inp[2])      tree_outp = 2'b11;
    else if (tree_inp[6]) tree_outp = 2'b11;
    else if (tree_inp[4]) tree_outp = 2'b10;
    else                  tree_outp = 2'b01;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b1111; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_req_ready got=%b exp=0000", req_ready); end
    tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests_run++; if (tree_inp !== 7'h00) begin tests_failed++; $display("FAIL reset_tree_inp got=%h exp=00", tree_inp); end
    tests_run++; if (res_class !== 2'b00) begin tests_failed++; $display("FAIL reset_res_class got=%b exp=00", res_class); end
    tests_run++; if (res_id !== 2'd0) begin tests_failed++; $display("FAIL reset_res_id got=%0d exp=0", res_id); end
    req_valid = 4'b0000;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL single_grant got=%b exp=0001", req_ready); end
    step();
    req_valid = 4'b0000;
    #1;
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL single_ready_eval got=%b exp=0000", req_ready); end
    tests_run++; if (busy !== 1'b1 || res_valid !== 1'b0) begin tests_failed++; $display("FAIL single_eval_state busy=%b res_valid=%b exp busy=1 res_valid=0", busy, res_valid); end
    tests_run++; if (tree_inp !== 7'h00) begin tests_failed++; $display("FAIL single_tree_inp got=%h exp=00", tree_inp); end
    step();
    $display("[TB] txn single id=%0d class=%b valid=%b", res_id, res_class, res_valid);
    tests_run++; if (res_valid !== 1'b1) begin tests_failed++; $display("FAIL single_res_valid got=%b exp=1", res_valid); end
    tests_run++; if (res_class !== 2'b01) begin tests_failed++; $display("FAIL single_res_class got=%b exp=01", res_class); end
    tests_run++; if (res_id !== 2'd0) begin tests_failed++; $display("FAIL single_res_id got=%0d exp=0", res_id); end
    step();
    tests_run++; if (res_valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL single_back_idle res_valid=%b busy=%b exp 0 0", res_valid, busy); end
  endtask

  task automatic test_contention();
    logic [3:0]  exp_ready [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [6:0]  exp_feat  [5] = '{7'h00, 7'h04, 7'h40, 7'h10, 7'h00};
    logic [1:0]  exp_cls   [5] = '{2'b01, 2'b11, 2'b11, 2'b10, 2'b01};
    logic [1:0]  exp_id    [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    rst_n = 1'b0; req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      tests_run++; if (req_ready !== exp_ready[i]) begin tests_failed++; $display("FAIL contention_grant[%0d] got=%b exp=%b", i, req_ready, exp_ready[i]); end
      step();
      tests_run++; if (tree_inp !== exp_feat[i]) begin tests_failed++; $display("FAIL contention_feat[%0d] got=%h exp=%h", i, tree_inp, exp_feat[i]); end
      step();
      $display("[TB] txn contention id=%0d class=%b valid=%b", res_id, res_class, res_valid);
      tests_run++; if (res_valid !== 1'b1 || res_id !== exp_id[i] || res_class !== exp_cls[i]) begin
        tests_failed++; $display("FAIL contention_res[%0d] got valid=%b id=%0d class=%b exp valid=1 id=%0d class=%b", i, res_valid, res_id, res_class, exp_id[i], exp_cls[i]);
      end
      step();
    end
    req_valid = 4'b0000;
    #1;
  endtask

  task automatic test_back_pressure();
    req_valid = 4'b0010;
    #1;
    tests_run++; if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL bp_grant got=%b exp=0010", req_ready); end
    step();
    req_valid = 4'b1000; res_ready = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      tests_run++; if (res_valid !== 1'b1 || res_class !== 2'b11 || res_id !== 2'd1) begin
        tests_failed++; $display("FAIL bp_hold[%0d] got valid=%b class=%b id=%0d exp valid=1 class=11 id=1", k, res_valid, res_class, res_id);
      end
      tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_ready[%0d] got=%b exp=0000", k, req_ready); end
      step();
    end
    $display("[TB] txn backpressure id=%0d class=%b valid=%b", res_id, res_class, res_valid);
    tests_run++; if (res_valid !== 1'b1 || res_id !== 2'd1) begin tests_failed++; $display("FAIL bp_still_valid got valid=%b id=%0d exp valid=1 id=1", res_valid, res_id); end
    res_ready = 1'b1;
    step();
    tests_run++; if (busy !== 1'b0 || res_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_idle busy=%b res_valid=%b exp 0 0", busy, res_valid); end
    tests_run++; if (req_ready !== 4'b1000) begin tests_failed++; $display("FAIL bp_next_grant got=%b exp=1000", req_ready); end
    step();
    req_valid = 4'b0000;
    tests_run++; if (busy !== 1'b1 || tree_inp !== 7'h10) begin tests_failed++; $display("FAIL bp_next_eval busy=%b tree_inp=%h exp 1 10", busy, tree_inp); end
    step();
    $display("[TB] txn backpressure id=%0d class=%b valid=%b", res_id, res_class, res_valid);
    tests_run++; if (res_valid !== 1'b1 || res_class !== 2'b10 || res_id !== 2'd3) begin
      tests_failed++; $display("FAIL bp_next_res got valid=%b class=%b id=%0d exp valid=1 class=10 id=3", res_valid, res_class, res_id);
    end
    step();
  endtask

  task automatic test_reset_midop();
    req_valid = 4'b0001;
    #1;
    tests_run++; if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL rst_pre_grant got=%b exp=0001", req_ready); end
    step();
    req_valid = 4'b0000;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_in_eval busy=%b exp=1", busy); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (busy !== 1'b0 || res_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_async_state busy=%b res_valid=%b exp 0 0", busy, res_valid); end
    tests_run++; if (res_class !== 2'b00 || res_id !== 2'd0 || tree_inp !== 7'h00) begin
      tests_failed++; $display("FAIL rst_async_regs class=%b id=%0d tree_inp=%h exp 00 0 00", res_class, res_id, tree_inp);
    end
    req_valid = 4'b0100;
    #1;
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL rst_ready_held got=%b exp=0000", req_ready); end
    for (int k = 0; k < 2; k++) begin
      step();
      tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_no_result[%0d] got=%b exp=0", k, res_valid); end
    end
    rst_n = 1'b1;
    #1;
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL rst_first_grant got=%b exp=0100", req_ready); end
    step();
    req_valid = 4'b0000;
    tests_run++; if (res_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_eval_no_result got=%b exp=0", res_valid); end
    step();
    $display("[TB] txn reset_midop id=%0d class=%b valid=%b", res_id, res_class, res_valid);
    tests_run++; if (res_valid !== 1'b1 || res_class !== 2'b11 || res_id !== 2'd2) begin
      tests_failed++; $display("FAIL rst_after_res got valid=%b class=%b id=%0d exp valid=1 class=11 id=2", res_valid, res_class, res_id);
    end
    step();
  endtask

`ifdef DTC_CLASS_HIST_EN
  task automatic test_hist();
    logic [7:0] exp_hist [4] = '{8'h40, 8'h80, 8'hC0, 8'hC0};
    rst_n = 1'b0; req_valid = 4'b0000; hist_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    tests_run++; if (hist !== 8'h00) begin tests_failed++; $display("FAIL hist_reset got=%h exp=00", hist); end
    for (int n = 0; n < 5; n++) begin
      req_valid = 4'b0010;
      step();
      req_valid = 4'b0000;
      step();
      if (n == 4) hist_clr = 1'b1;
      step();
      hist_clr = 1'b0;
      $display("[TB] txn hist id=%0d class=%b hist=%h", res_id, res_class, hist);
      if (n < 4) begin
        tests_run++; if (hist !== exp_hist[n]) begin tests_failed++; $display("FAIL hist_count[%0d] got=%h exp=%h", n, hist, exp_hist[n]); end
      end else begin
        tests_run++; if (hist !== 8'h00) begin tests_failed++; $display("FAIL hist_clr_priority got=%h exp=00", hist); end
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; res_ready = 1'b1;
    req_feat = {7'h10, 7'h40, 7'h04, 7'h00};
`ifdef DTC_CLASS_HIST_EN
    hist_clr = 1'b0;
`endif
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_reset_midop();
`ifdef DTC_CLASS_HIST_EN
    test_hist();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
